// File: rtl/imm_extend_unit.sv
// rtl/imm_extend_unit.sv - immediate extension unit with output register and skid buffer
module imm_extend_unit #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  imm_in,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] ext_out,
    output logic [1:0]       ext_mode
);

    localparam logic [1:0] MODE_ZERO   = 2'd0;
    localparam logic [1:0] MODE_SIGN   = 2'd1;
    localparam logic [1:0] MODE_UPPER  = 2'd2;
    localparam logic [1:0] MODE_BRANCH = 2'd3;

    // Refuse to build a unit whose branch result could not hold the shifted field.
    if (OUT_W < IN_W + BR_SHIFT || IN_W < 2) begin : g_bad_params
        $error("imm_extend_unit: need OUT_W >= IN_W + BR_SHIFT and IN_W >= 2");
    end

    logic [OUT_W-1:0] zext_val;
    logic [OUT_W-1:0] sext_val;
    logic [OUT_W-1:0] ext_val;

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [1:0]       out_mode_q, out_mode_d;
    logic             skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0] skid_data_q, skid_data_d;
    logic [1:0]       skid_mode_q, skid_mode_d;
    logic             in_ready_q, in_ready_d;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    // Build all four extension flavours from the raw field and pick one by mode.
    always_comb begin
        zext_val = '0;
        zext_val[IN_W-1:0] = imm_in;
        sext_val = zext_val;
        for (int i = IN_W; i < OUT_W; i++) begin
            sext_val[i] = imm_in[IN_W-1];
        end
        case (mode)
            MODE_ZERO:   ext_val = zext_val;
            MODE_SIGN:   ext_val = sext_val;
            MODE_UPPER:  ext_val = zext_val << (OUT_W - IN_W);
            MODE_BRANCH: ext_val = sext_val << BR_SHIFT;
            default:     ext_val = zext_val;
        endcase
    end

    // Next-state for the output/skid pair; the skid always drains before new input is taken.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_mode_d   = out_mode_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_mode_d  = skid_mode_q;
        if (skid_valid_q) begin
            if (out_ready) begin
                out_data_d   = skid_data_q;
                out_mode_d   = skid_mode_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = ext_val;
                out_mode_d  = mode;
                out_valid_d = 1'b1;
            end else begin
                skid_data_d  = ext_val;
                skid_mode_d  = mode;
                skid_valid_d = 1'b1;
            end
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
        in_ready_d = !skid_valid_d;
    end

    // State registers; reset clears both stages and reopens the input.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_mode_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_mode_q  <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_mode_q   <= out_mode_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_mode_q  <= skid_mode_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign ext_out   = out_data_q;
    assign ext_mode  = out_mode_q;

endmodule

// File: tb/tb_imm_extend_unit.sv
// tb/tb_imm_extend_unit.sv - scoreboard bench for imm_extend_unit
module tb_imm_extend_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] imm_in;
    logic [1:0]  mode, ext_mode;
    logic [31:0] ext_out;

    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [11:0] imm_in2;
    logic [1:0]  mode2, ext_mode2;
    logic [31:0] ext_out2;

    int checks = 0;
    int errors = 0;

    logic [33:0] sb_q[$];
    logic [31:0] cur_exp;
    logic        hold_v;
    logic [33:0] hold_val;

    imm_extend_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .imm_in(imm_in), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .ext_out(ext_out), .ext_mode(ext_mode)
    );

    imm_extend_unit #(.IN_W(12), .OUT_W(32), .BR_SHIFT(1)) dut12 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .imm_in(imm_in2), .mode(mode2), .out_valid(out_valid2), .out_ready(out_ready2),
        .ext_out(ext_out2), .ext_mode(ext_mode2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops and compares on every output transfer, pushes on every input transfer.
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_data", ext_out, hold_val[31:0]);
                chk("hold_mode", {30'b0, ext_mode}, {30'b0, hold_val[33:32]});
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_output", 32'd1, 32'd0);
                end else begin
                    logic [33:0] e;
                    e = sb_q.pop_front();
                    chk("result_data", ext_out, e[31:0]);
                    chk("result_mode", {30'b0, ext_mode}, {30'b0, e[33:32]});
                end
            end
            hold_v   = out_valid && !out_ready;
            hold_val = {ext_mode, ext_out};
            if (in_valid && in_ready) sb_q.push_back({mode, cur_exp});
        end
    end

    // Present one pair starting at posedge+1 and hold it until it is accepted.
    task automatic send(input logic [15:0] imm, input logic [1:0] md, input logic [31:0] exp);
        int n;
        imm_in   = imm;
        mode     = md;
        cur_exp  = exp;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send12(input logic [11:0] imm, input logic [1:0] md, input logic [31:0] exp);
        int n;
        imm_in2   = imm;
        mode2     = md;
        in_valid2 = 1'b1;
        @(negedge clk);
        chk("p12_in_ready", {31'b0, in_ready2}, 32'd1);
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid2 && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("p12_out_valid", {31'b0, out_valid2}, 32'd1);
        chk("p12_data", ext_out2, exp);
        chk("p12_mode", {30'b0, ext_mode2}, {30'b0, md});
        @(posedge clk);
        #1;
    endtask

    logic [15:0] v_imm [9] = '{16'h8001, 16'h1234, 16'hFFFF, 16'h7FFF, 16'h7FFF,
                               16'hFFFF, 16'hFFFF, 16'h8000, 16'h0000};
    logic [1:0]  v_mode[9] = '{2'd0, 2'd2, 2'd3, 2'd3, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1};
    logic [31:0] v_exp [9] = '{32'h0000_8001, 32'h1234_0000, 32'hFFFF_FFFC, 32'h0001_FFFC,
                               32'h0000_7FFF, 32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFE_0000,
                               32'h0000_0000};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; imm_in = '0; mode = '0; cur_exp = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b1; imm_in2 = '0; mode2 = '0;
        hold_v = 1'b0; hold_val = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_ext_out", ext_out, 32'd0);
        chk("rst_ext_mode", {30'b0, ext_mode}, 32'd0);
        @(posedge clk);
        #1;

        // One-cycle latency on a lone SIGN vector.
        send(16'h8001, 2'd1, 32'hFFFF_8001);
        @(negedge clk);
        chk("latency_out_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk);
        #1;

        // Directed table with intermittent back-pressure.
        for (int i = 0; i < 9; i++) begin
            out_ready = (i % 3 != 2);
            send(v_imm[i], v_mode[i], v_exp[i]);
        end
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Sustained throughput: one result per cycle.
        for (int i = 0; i < 8; i++) begin
            imm_in   = 16'(16'hFFF8 + i);
            mode     = 2'd1;
            cur_exp  = 32'(32'hFFFF_FFF8 + i);
            in_valid = 1'b1;
            @(negedge clk);
            chk("stream_in_ready", {31'b0, in_ready}, 32'd1);
            if (i > 0) chk("stream_out_valid", {31'b0, out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_last_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1;

        // Back-pressure: A fills output, B fills skid, C is held off.
        out_ready = 1'b0;
        send(16'h0001, 2'd1, 32'h0000_0001);
        send(16'h0002, 2'd0, 32'h0000_0002);
        imm_in = 16'h0003; mode = 2'd2; cur_exp = 32'h0003_0000; in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_in_ready_low2", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_a_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_a_data", ext_out, 32'h0000_0001);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_b_data", ext_out, 32'h0000_0002);
        chk("bp_in_ready_back", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_c_data", ext_out, 32'h0003_0000);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_drained", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Reset mid-stream with both stages full and out_ready rising in the same cycle.
        out_ready = 1'b0;
        send(16'h00C1, 2'd0, 32'h0000_00C1);
        send(16'h00C2, 2'd0, 32'h0000_00C2);
        reset = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_rst_ext_out", ext_out, 32'd0);
        chk("mid_rst_ext_mode", {30'b0, ext_mode}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        send(16'h00AA, 2'd0, 32'h0000_00AA);
        repeat (3) @(posedge clk);
        #1;

        // Alternate build: 12-bit field, single-bit branch shift.
        send12(12'h800, 2'd3, 32'hFFFF_F000);
        send12(12'h7FF, 2'd1, 32'h0000_07FF);
        send12(12'hABC, 2'd2, 32'hABC0_0000);
        send12(12'hFFF, 2'd0, 32'h0000_0FFF);

        repeat (2) @(posedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
